// File: rtl/bus_reg_slave_pkg.sv
// Shared constants, state encoding and small helpers for the bus register slave.
// Bus polarities follow the system bus: strobes and selects are active-low.
package bus_reg_slave_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    // An access request needs both the decoder select and the master strobe.
    function automatic logic bus_select(input logic cs_n, input logic as_n);
        return (cs_n == ENABLE_) && (as_n == ENABLE_);
    endfunction

    function automatic logic [WORD_DATA_W-1:0] count_inc(input logic [WORD_DATA_W-1:0] cnt);
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/bus_reg_slave.sv
// Register-file slave with programmable wait states and a read-only access counter
// in the top word. Each accepted access yields exactly one registered rdy_ pulse.
module bus_reg_slave
    import bus_reg_slave_pkg::*;
#(
    parameter int DEPTH_W     = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   rdy_
);

    localparam int                     NUM_WORDS = 2 ** DEPTH_W;
    localparam logic [DEPTH_W-1:0]     CNT_IDX   = DEPTH_W'(NUM_WORDS - 1);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST = WAIT_CNT_W'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic                   r_rw;
    logic [DEPTH_W-1:0]     r_idx;
    logic [WORD_DATA_W-1:0] r_wdata;
    logic [WORD_DATA_W-1:0] r_regs [NUM_WORDS];
    logic [WORD_DATA_W-1:0] r_acc_cnt;
    logic [WORD_DATA_W-1:0] r_rd_data;
    logic                   r_rdy_n;

    logic                   w_accept;
    logic                   w_enter_ack;
    logic                   w_acc_rw;
    logic [DEPTH_W-1:0]     w_acc_idx;
    logic [WORD_DATA_W-1:0] w_acc_wdata;
    logic [WORD_DATA_W-1:0] w_rd_word;
    logic                   w_unused_addr_hi;

    // Upper address bits are the decoder's business; fold them away explicitly.
    assign w_unused_addr_hi = ^addr[WORD_ADDR_W-1:DEPTH_W];

    // Accept condition: only the idle state samples the bus.
    always_comb begin
        w_accept = 1'b0;
        if (r_state == ST_IDLE) begin
            w_accept = bus_select(cs_, as_);
        end else begin
            w_accept = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_ack = (w_state_nxt == ST_ACK);

    // With zero wait states the commit edge is also the accept edge, so the live bus is used.
    always_comb begin
        w_acc_rw    = r_rw;
        w_acc_idx   = r_idx;
        w_acc_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_acc_rw    = rw;
            w_acc_idx   = addr[DEPTH_W-1:0];
            w_acc_wdata = wr_data;
        end else begin
            w_acc_rw    = r_rw;
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
        end
    end

    // Read word selection; the top index returns the pre-increment access count.
    always_comb begin
        w_rd_word = r_regs[w_acc_idx];
        if (w_acc_idx == CNT_IDX) begin
            w_rd_word = r_acc_cnt;
        end else begin
            w_rd_word = r_regs[w_acc_idx];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter and latched access fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_rw       <= READ;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= WAIT_LOAD;
            r_rw       <= rw;
            r_idx      <= addr[DEPTH_W-1:0];
            r_wdata    <= wr_data;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt - WAIT_LAST;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Register file; the counter slot is never written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_enter_ack && (w_acc_rw == WRITE) && (w_acc_idx != CNT_IDX)) begin
            r_regs[w_acc_idx] <= w_acc_wdata;
        end else begin
            r_regs[w_acc_idx] <= r_regs[w_acc_idx];
        end
    end

    // Access counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_cnt <= '0;
        end else if (w_enter_ack) begin
            r_acc_cnt <= count_inc(r_acc_cnt);
        end else begin
            r_acc_cnt <= r_acc_cnt;
        end
    end

    // Registered bus outputs: data is non-zero only during the ready cycle of a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdy_n   <= DISABLE_;
            r_rd_data <= '0;
        end else if (w_enter_ack) begin
            r_rdy_n   <= ENABLE_;
            r_rd_data <= (w_acc_rw == READ) ? w_rd_word : 32'd0;
        end else begin
            r_rdy_n   <= DISABLE_;
            r_rd_data <= 32'd0;
        end
    end

    assign rdy_    = r_rdy_n;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Bench for bus_reg_slave: one zero-wait and one three-wait instance, a transaction-level
// model compared every cycle, plus directed checks with hand-computed values.
module tb_bus_reg_slave;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        cs_n   [2];
    logic        as_n   [2];
    logic        rw_s   [2];
    logic [29:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rd_s   [2];
    logic        rdy_s  [2];

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_reg_slave #(.DEPTH_W(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst[0]), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rw_s[0]),
        .addr(addr_s[0]), .wr_data(wd_s[0]), .rd_data(rd_s[0]), .rdy_(rdy_s[0]));

    bus_reg_slave #(.DEPTH_W(4), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst[1]), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rw_s[1]),
        .addr(addr_s[1]), .wr_data(wd_s[1]), .rd_data(rd_s[1]), .rdy_(rdy_s[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Transaction model: an accepted access completes WAIT edges later; the slave is
    // free again two edges after completion.
    logic [31:0] m_mem   [2][16];
    logic [31:0] m_cnt   [2];
    logic        m_pend  [2];
    int          m_ack   [2];
    int          m_free  [2];
    logic        m_lrw   [2];
    logic [3:0]  m_lidx  [2];
    logic [31:0] m_ldat  [2];
    logic        exp_rdy [2];
    logic [31:0] exp_dat [2];
    int          edge_n = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                for (int k = 0; k < 16; k++) m_mem[i][k] <= 32'd0;
                m_cnt[i]   <= 32'd0;
                m_pend[i]  <= 1'b0;
                m_free[i]  <= 0;
                exp_rdy[i] <= 1'b1;
                exp_dat[i] <= 32'd0;
            end else begin
                automatic logic        pend = m_pend[i];
                automatic int          ack  = m_ack[i];
                automatic logic        lrw  = m_lrw[i];
                automatic logic [3:0]  lidx = m_lidx[i];
                automatic logic [31:0] ldat = m_ldat[i];
                automatic logic        rdy  = 1'b1;
                automatic logic [31:0] dat  = 32'd0;
                if (!pend && edge_n >= m_free[i] && cs_n[i] == 1'b0 && as_n[i] == 1'b0) begin
                    pend = 1'b1;
                    ack  = edge_n + wait_of(i);
                    lrw  = rw_s[i];
                    lidx = addr_s[i][3:0];
                    ldat = wd_s[i];
                end
                if (pend && edge_n == ack) begin
                    rdy = 1'b0;
                    if (lrw == 1'b1) dat = (lidx == 4'd15) ? m_cnt[i] : m_mem[i][lidx];
                    else if (lidx != 4'd15) m_mem[i][lidx] <= ldat;
                    m_cnt[i]  <= m_cnt[i] + 32'd1;
                    m_free[i] <= edge_n + 2;
                    pend = 1'b0;
                end
                m_pend[i]  <= pend;
                m_ack[i]   <= ack;
                m_lrw[i]   <= lrw;
                m_lidx[i]  <= lidx;
                m_ldat[i]  <= ldat;
                exp_rdy[i] <= rdy;
                exp_dat[i] <= dat;
            end
        end
        edge_n <= edge_n + 1;
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rdy0",  {31'd0, rdy_s[0]}, {31'd0, exp_rdy[0]});
            chk("model_data0", rd_s[0], exp_dat[0]);
            chk("model_rdy1",  {31'd0, rdy_s[1]}, {31'd0, exp_rdy[1]});
            chk("model_data1", rd_s[1], exp_dat[1]);
        end
    end

    task automatic access(input int s, input logic r, input logic [3:0] idx,
                          input logic [31:0] d, output logic [31:0] rdat, output int lat);
        @(negedge clk);
        cs_n[s] = 1'b0; as_n[s] = 1'b0; rw_s[s] = r;
        addr_s[s] = {26'h2AAAAAA, idx}; wd_s[s] = d;
        lat = 0; rdat = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rdy_s[s] == 1'b0) begin
                lat = c; rdat = rd_s[s];
                break;
            end
        end
        as_n[s] = 1'b1; cs_n[s] = 1'b1;
    endtask

    logic [31:0] rdat;
    int          lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cs_n[i] = 1'b1; as_n[i] = 1'b1; rw_s[i] = 1'b1;
            addr_s[i] = 30'd0; wd_s[i] = 32'd0;
        end
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk("reset_rdy", {31'd0, rdy_s[1]}, 32'd1);
        chk("reset_data", rd_s[1], 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Zero wait states
        access(0, 1'b0, 4'd3, 32'hDEADBEEF, rdat, lat);
        chk("w0_write_lat", lat, 32'd1);
        access(0, 1'b1, 4'd3, 32'd0, rdat, lat);
        chk("w0_read_lat", lat, 32'd1);
        chk("w0_read_data", rdat, 32'hDEADBEEF);
        @(negedge clk);
        chk("w0_data_idle", rd_s[0], 32'd0);

        // Counter word
        access(1, 1'b1, 4'd15, 32'd0, rdat, lat);
        chk("cnt_after_reset", rdat, 32'd0);
        access(1, 1'b0, 4'd15, 32'h0000FFFF, rdat, lat);
        chk("cnt_write_lat", lat, 32'd4);
        access(1, 1'b1, 4'd15, 32'd0, rdat, lat);
        chk("cnt_read_two", rdat, 32'd2);

        // Strobe without select
        @(negedge clk);
        cs_n[1] = 1'b1; as_n[1] = 1'b0; rw_s[1] = 1'b1; addr_s[1] = 30'd15;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("nosel_rdy", {31'd0, rdy_s[1]}, 32'd1);
        end
        as_n[1] = 1'b1;
        access(1, 1'b1, 4'd15, 32'd0, rdat, lat);
        chk("nosel_cnt", rdat, 32'd3);

        // Wait states
        access(1, 1'b0, 4'd0, 32'h12345678, rdat, lat);
        chk("w3_write_lat", lat, 32'd4);
        access(1, 1'b1, 4'd0, 32'd0, rdat, lat);
        chk("w3_read_lat", lat, 32'd4);
        chk("w3_read_data", rdat, 32'h12345678);

        // Reset in the middle of a waited write
        @(negedge clk);
        cs_n[1] = 1'b0; as_n[1] = 1'b0; rw_s[1] = 1'b0;
        addr_s[1] = 30'd1; wd_s[1] = 32'hA5A5A5A5;
        @(negedge clk); @(negedge clk);
        rst[1] = 1'b1; cs_n[1] = 1'b1; as_n[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_rdy", {31'd0, rdy_s[1]}, 32'd1);
        end
        access(1, 1'b1, 4'd15, 32'd0, rdat, lat);
        chk("abort_cnt", rdat, 32'd0);
        access(1, 1'b1, 4'd1, 32'd0, rdat, lat);
        chk("abort_word", rdat, 32'd0);

        // Strobe held across ACK: two accesses five cycles apart
        begin
            int pulses = 0;
            int p1 = 0;
            int p2 = 0;
            logic [31:0] d1 = 32'd0;
            logic [31:0] d2 = 32'd0;
            @(negedge clk);
            cs_n[1] = 1'b0; as_n[1] = 1'b0; rw_s[1] = 1'b1; addr_s[1] = 30'd15;
            for (int c = 1; c <= 16; c++) begin
                @(negedge clk);
                if (rdy_s[1] == 1'b0) begin
                    pulses++;
                    if (pulses == 1) begin p1 = c; d1 = rd_s[1]; end
                    else begin p2 = c; d2 = rd_s[1]; end
                end
                if (c == 6) begin cs_n[1] = 1'b1; as_n[1] = 1'b1; end
            end
            chk("held_pulses", pulses, 32'd2);
            chk("held_first", p1, 32'd4);
            chk("held_period", p2 - p1, 32'd5);
            chk("held_data1", d1, 32'd2);
            chk("held_data2", d2, 32'd3);
        end
        access(1, 1'b1, 4'd15, 32'd0, rdat, lat);
        chk("held_cnt", rdat, 32'd4);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
